// File: rtl/fpa_pkg.sv
// fpa_pkg: shared widths, exception codes and operand layout for the 8-bit FPA datapath
// Build option: FPA_ROUND_EN adds one guard bit below the mantissa for round-half-up.
package fpa_pkg;
  localparam int EXP_W  = 4;
  localparam int FRAC_W = 3;
  localparam int BIAS   = 7;
  localparam logic [EXP_W-1:0] EXP_MAX = 4'd15;
  localparam int MANT_W = FRAC_W + 2;
`ifdef FPA_ROUND_EN
  localparam int GRD_W = 1;
`else
  localparam int GRD_W = 0;
`endif
  localparam int WRK_W = MANT_W + GRD_W;
  localparam logic [1:0] EXC_OK  = 2'b00;
  localparam logic [1:0] EXC_INF = 2'b01;
  localparam logic [1:0] EXC_OVF = 2'b10;
  localparam logic [1:0] EXC_UNF = 2'b11;
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fpa_t;
endpackage

// File: rtl/fpa_align.sv
// fpa_align: combinational exponent compare and mantissa alignment
// Ports: a, b operands in; a_big (a keeps its mantissa), exp_c common exponent,
//        wa, wb aligned working mantissas {carry, hidden, frac[, guard]}.
// Build option: FPA_ROUND_EN widens the working mantissas by a guard bit.
module fpa_align
  import fpa_pkg::*;
(
  input  fpa_t             a,
  input  fpa_t             b,
  output logic             a_big,
  output logic [EXP_W-1:0] exp_c,
  output logic [WRK_W-1:0] wa,
  output logic [WRK_W-1:0] wb
);
  logic [EXP_W-1:0] diff;
  logic [WRK_W-1:0] ra, rb, sm;
  always_comb begin
    a_big = a.exp >= b.exp;
    exp_c = a_big ? a.exp : b.exp;
    diff  = a_big ? a.exp - b.exp : b.exp - a.exp;
    ra    = WRK_W'({2'b00, |a.exp, a.frac}) << GRD_W;
    rb    = WRK_W'({2'b00, |b.exp, b.frac}) << GRD_W;
    sm    = diff > 4'd4 ? '0 : (a_big ? rb : ra) >> diff;
    wa    = a_big ? ra : sm;
    wb    = a_big ? sm : rb;
  end
endmodule

// File: rtl/fpa_datapath.sv
// fpa_datapath: strobe-driven 8-bit floating-point add/normalize datapath
// Ports: clk, clr (async, active-high); a_in, b_in operands {sign, exp, frac};
//        load_en, add_en, norm_load, norm_en, shift_right, shift_left, done_en step strobes;
//        add_except, norm_except abort flags; mant working mantissa;
//        result, result_valid (one-cycle pulse), exc_code.
// Build option: FPA_ROUND_EN rounds half-up on done_en using the guard bit.
module fpa_datapath
  import fpa_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic       load_en,
  input  logic       add_en,
  input  logic       norm_load,
  input  logic       norm_en,
  input  logic       shift_right,
  input  logic       shift_left,
  input  logic       done_en,
  output logic       add_except,
  output logic       norm_except,
  output logic [4:0] mant,
  output logic [7:0] result,
  output logic       result_valid,
  output logic [1:0] exc_code
);
  fpa_t             a, b;
  logic             a_big;
  logic [EXP_W-1:0] exp_c, ce_r, nexp, exp_inc, exp_dec;
  logic [WRK_W-1:0] wa, wb, wa_r, wb_r, sum_r, wk, add_w;
  logic             sa, sb, ia, ib, s_sign, n_sign, add_s, gt, eq_s;
  logic [7:0]       d_res;
  logic [1:0]       d_exc;
  assign a = fpa_t'(a_in);
  assign b = fpa_t'(b_in);
  assign mant = wk[GRD_W +: MANT_W];
  fpa_align u_align (.a(a), .b(b), .a_big(a_big), .exp_c(exp_c), .wa(wa), .wb(wb));
  always_comb begin
    eq_s    = sa == sb;
    gt      = wa_r >= wb_r;
    add_w   = eq_s ? wa_r + wb_r : gt ? wa_r - wb_r : wb_r - wa_r;
    add_s   = add_w == '0 ? 1'b0 : (eq_s || gt) ? sa : sb;
    exp_inc = nexp + 1'b1;
    exp_dec = nexp - 1'b1;
  end
`ifdef FPA_ROUND_EN
  logic [FRAC_W:0]  rnd;
  logic [EXP_W-1:0] rexp;
  // A frac carry-out bumps the exponent; frac wraps to 000, so reaching 15 is already inf.
  always_comb begin
    rnd   = {1'b0, wk[GRD_W +: FRAC_W]} + {{FRAC_W{1'b0}}, wk[0]};
    rexp  = nexp + {{(EXP_W-1){1'b0}}, rnd[FRAC_W]};
    d_res = {n_sign, rexp, rnd[FRAC_W-1:0]};
    d_exc = (rnd[FRAC_W] && rexp == EXP_MAX) ? EXC_OVF : EXC_OK;
  end
`else
  always_comb begin
    d_res = {n_sign, nexp, wk[FRAC_W-1:0]};
    d_exc = EXC_OK;
  end
`endif
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      {sa, sb, ia, ib, s_sign, n_sign} <= '0;
      {wa_r, wb_r, sum_r, wk} <= '0;
      {ce_r, nexp} <= '0;
      {add_except, norm_except, result_valid} <= '0;
      result <= '0;
      exc_code <= '0;
    end else begin
      result_valid <= 1'b0;
      if (load_en) begin
        sa <= a.sign;
        sb <= b.sign;
        ia <= a.exp == EXP_MAX;
        ib <= b.exp == EXP_MAX;
        wa_r <= wa;
        wb_r <= wb;
        ce_r <= exp_c;
        add_except <= 1'b0;
        norm_except <= 1'b0;
      end else if (add_en) begin
        sum_r <= add_w;
        s_sign <= add_s;
        if (ia || ib) begin
          add_except <= 1'b1;
          result <= {ia ? sa : sb, 7'h78};
          exc_code <= EXC_INF;
          result_valid <= 1'b1;
        end else if (add_w == '0) begin
          add_except <= 1'b1;
          result <= 8'h00;
          exc_code <= EXC_OK;
          result_valid <= 1'b1;
        end
      end else if (norm_load) begin
        wk <= sum_r;
        n_sign <= s_sign;
        nexp <= ce_r;
      end else if (norm_en && (shift_right ^ shift_left)) begin
        wk <= shift_right ? wk >> 1 : wk << 1;
        nexp <= shift_right ? exp_inc : exp_dec;
        if (shift_right && exp_inc == EXP_MAX) begin
          norm_except <= 1'b1;
          result <= {n_sign, 7'h78};
          exc_code <= EXC_OVF;
          result_valid <= 1'b1;
        end
        if (shift_left && exp_dec == '0) begin
          norm_except <= 1'b1;
          result <= {n_sign, 7'h00};
          exc_code <= EXC_UNF;
          result_valid <= 1'b1;
        end
      end else if (done_en) begin
        result <= d_res;
        exc_code <= d_exc;
        result_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpa_datapath.sv
// tb_fpa_datapath: directed table, hand sequences and random ops against an arithmetic model
module tb_fpa_datapath;
`ifdef FPA_ROUND_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  logic clk = 0, clr;
  logic [7:0] a_in, b_in;
  logic load_en, add_en, norm_load, norm_en, shift_right, shift_left, done_en;
  logic add_except, norm_except, result_valid;
  logic [4:0] mant;
  logic [7:0] result;
  logic [1:0] exc_code;
  int checks = 0, failures = 0;
  typedef struct {
    logic [7:0] a, b;
    int nr, nl;
    logic [4:0] mld, mfin;
    logic [7:0] res;
    logic [1:0] exc;
    logic aex, nex;
  } vec_t;
  vec_t tbl[11];
  fpa_datapath dut (
    .clk(clk), .clr(clr), .a_in(a_in), .b_in(b_in),
    .load_en(load_en), .add_en(add_en), .norm_load(norm_load), .norm_en(norm_en),
    .shift_right(shift_right), .shift_left(shift_left), .done_en(done_en),
    .add_except(add_except), .norm_except(norm_except), .mant(mant),
    .result(result), .result_valid(result_valid), .exc_code(exc_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, " mant"}, 8'(mant), 8'h00);
    chk({tag, " result"}, result, 8'h00);
    chk({tag, " exc"}, 8'(exc_code), 8'h00);
    chk({tag, " flags"}, {5'b0, add_except, norm_except, result_valid}, 8'h00);
  endtask
  // Numeric reference: signed integer sum of aligned significands, then normalize by value.
  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    int ea, eb, ma, mb, s, mag, e, fr;
    logic sg;
    ea = int'(a[6:3]);
    eb = int'(b[6:3]);
    ma = ((ea != 0) ? 8 : 0) + int'(a[2:0]);
    mb = ((eb != 0) ? 8 : 0) + int'(b[2:0]);
    v = '{a, b, 0, 0, 5'd0, 5'd0, 8'h00, 2'd0, 1'b0, 1'b0};
    if (ea == 15 || eb == 15) begin
      v.aex = 1;
      v.exc = 2'd1;
      v.res = {(ea == 15) ? a[7] : b[7], 7'h78};
      return v;
    end
    ma = ma << G;
    mb = mb << G;
    if (ea >= eb) begin
      mb = (ea - eb > 4) ? 0 : mb >> (ea - eb);
      e = ea;
    end else begin
      ma = (eb - ea > 4) ? 0 : ma >> (eb - ea);
      e = eb;
    end
    s = (a[7] ? -ma : ma) + (b[7] ? -mb : mb);
    if (s == 0) begin
      v.aex = 1;
      return v;
    end
    sg = s < 0;
    mag = sg ? -s : s;
    v.mld = 5'(mag >> G);
    if (mag >= (16 << G)) begin
      v.nr = 1;
      mag = mag >> 1;
      e++;
      if (e == 15) begin
        v.nex = 1;
        v.exc = 2'd2;
        v.res = {sg, 7'h78};
      end
    end else begin
      while (mag < (8 << G) && !v.nex) begin
        v.nl++;
        mag = mag << 1;
        e--;
        if (e == 0) begin
          v.nex = 1;
          v.exc = 2'd3;
          v.res = {sg, 7'h00};
        end
      end
    end
    v.mfin = 5'(mag >> G);
    if (!v.nex) begin
      fr = (mag >> G) % 8;
      if (G > 0) fr += mag % 2;
      if (fr == 8) begin
        fr = 0;
        e++;
      end
      v.res = (e == 15) ? {sg, 7'h78} : {sg, 4'(e), 3'(fr)};
      v.exc = (e == 15) ? 2'd2 : 2'd0;
    end
    return v;
  endfunction
  task automatic do_op(input vec_t v, input string tag);
    a_in = v.a;
    b_in = v.b;
    load_en = 1;
    tick();
    load_en = 0;
    chk({tag, " load flags"}, {6'b0, add_except, norm_except}, 8'h00);
    add_en = 1;
    tick();
    add_en = 0;
    chk({tag, " add_except"}, 8'(add_except), 8'(v.aex));
    if (v.aex) begin
      chk({tag, " abort result"}, result, v.res);
      chk({tag, " abort exc"}, 8'(exc_code), 8'(v.exc));
      chk({tag, " abort valid"}, 8'(result_valid), 8'h01);
      tick();
      chk({tag, " abort valid drop"}, 8'(result_valid), 8'h00);
      return;
    end
    chk({tag, " add no valid"}, 8'(result_valid), 8'h00);
    norm_load = 1;
    tick();
    norm_load = 0;
    chk({tag, " mant load"}, 8'(mant), 8'(v.mld));
    norm_en = 1;
    shift_right = 1;
    repeat (v.nr) tick();
    shift_right = 0;
    shift_left = 1;
    repeat (v.nl) tick();
    shift_left = 0;
    norm_en = 0;
    chk({tag, " mant shifted"}, 8'(mant), 8'(v.mfin));
    chk({tag, " norm_except"}, 8'(norm_except), 8'(v.nex));
    if (!v.nex) begin
      done_en = 1;
      tick();
      done_en = 0;
    end
    chk({tag, " result"}, result, v.res);
    chk({tag, " exc"}, 8'(exc_code), 8'(v.exc));
    chk({tag, " valid"}, 8'(result_valid), 8'h01);
    tick();
    chk({tag, " valid drop"}, 8'(result_valid), 8'h00);
    chk({tag, " flag held"}, 8'(norm_except), 8'(v.nex));
  endtask
  initial begin
    vec_t v;
    logic [7:0] ra, rb;
    tbl[0]  = '{8'h38, 8'h38, 1, 0, 5'b10000, 5'b01000, 8'h40, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'h38, 8'h30, 0, 0, 5'b01100, 5'b01100, 8'h3C, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{8'h38, 8'hB4, 0, 2, 5'b00010, 5'b01000, 8'h28, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{8'h3C, 8'hBC, 0, 0, 5'b00000, 5'b00000, 8'h00, 2'd0, 1'b1, 1'b0};
    tbl[4]  = '{8'h78, 8'h38, 0, 0, 5'b00000, 5'b00000, 8'h78, 2'd1, 1'b1, 1'b0};
    tbl[5]  = '{8'h70, 8'h70, 1, 0, 5'b10000, 5'b01000, 8'h78, 2'd2, 1'b0, 1'b1};
    tbl[6]  = '{8'h38, 8'hF8, 0, 0, 5'b00000, 5'b00000, 8'hF8, 2'd1, 1'b1, 1'b0};
    tbl[7]  = '{8'h00, 8'h38, 0, 0, 5'b01000, 5'b01000, 8'h38, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{8'h70, 8'h38, 0, 0, 5'b01000, 5'b01000, 8'h70, 2'd0, 1'b0, 1'b0};
    tbl[9]  = '{8'h8C, 8'h08, 0, 1, 5'b00100, 5'b01000, 8'h80, 2'd3, 1'b0, 1'b1};
    tbl[10] = '{8'h00, 8'h00, 0, 0, 5'b00000, 5'b00000, 8'h00, 2'd0, 1'b1, 1'b0};
    {load_en, add_en, norm_load, norm_en, shift_right, shift_left, done_en} = '0;
    a_in = 0;
    b_in = 0;
    clr = 1;
    #2;
    all_zero("reset");
    repeat (2) @(posedge clk);
    #1 clr = 0;
    foreach (tbl[i]) do_op(tbl[i], $sformatf("tbl%0d", i));
    // load_en beats add_en and clears the flag left by the cancelled add above
    a_in = 8'h38;
    b_in = 8'h38;
    load_en = 1;
    add_en = 1;
    tick();
    {load_en, add_en} = '0;
    chk("load priority flag", 8'(add_except), 8'h00);
    chk("load priority valid", 8'(result_valid), 8'h00);
    add_en = 1;
    tick();
    add_en = 0;
    // norm_load beats a shift; norm_en with both or neither shift holds
    {norm_load, norm_en, shift_right} = 3'b111;
    tick();
    {norm_load, norm_en, shift_right} = '0;
    chk("norm_load priority", 8'(mant), 8'h10);
    {norm_en, shift_right, shift_left} = 3'b111;
    tick();
    chk("both shifts hold", 8'(mant), 8'h10);
    {shift_right, shift_left} = '0;
    tick();
    norm_en = 0;
    chk("no shift hold", 8'(mant), 8'h10);
    // asynchronous clear between norm_load and the first shift
    #2 clr = 1;
    #1 all_zero("clr mid-op");
    #2 clr = 0;
    tick();
    all_zero("after clr");
    do_op(tbl[0], "restart");
    // clear while the result_valid pulse is high
    do_op(tbl[1], "pre-clr");
    a_in = 8'h38;
    b_in = 8'h30;
    load_en = 1;
    tick();
    load_en = 0;
    add_en = 1;
    tick();
    add_en = 0;
    norm_load = 1;
    tick();
    norm_load = 0;
    done_en = 1;
    tick();
    done_en = 0;
    chk("pulse before clr", 8'(result_valid), 8'h01);
    #2 clr = 1;
    #1 all_zero("clr on pulse");
    #2 clr = 0;
    tick();
    for (int n = 0; n < 300; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      v = model(ra, rb);
      do_op(v, $sformatf("rnd %h+%h", ra, rb));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
